truth_table_sweeper: RTL and testbench

Self-checking stimulus/capture stage wrapped around a combinational N-input boolean function such as `minimized_function`. On `start` it drives every input vector 0 … 2^N_IN−1 onto the function, waits a programmable settle time, samples the function output `f` into an 2^N_IN-bit truth table, and compares it with an expected table. It replaces free-running `#delay` sweeps with a clocked, synthesizable sweeper usable both in benches and on hardware.

---
 rtl/truth_table_sweeper_pkg.sv | 7 +
 rtl/truth_table_sweeper_settle_timer.sv | 16 +
 rtl/truth_table_sweeper.sv | 81 ++++++++
 tb/tb_truth_table_sweeper.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// sweeper_pkg: shared state encoding and table sizing for the truth-table sweeper
package sweeper_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} sweep_state_t;
  function automatic int n_vec(input int n_in);
    return 1 << n_in;
  endfunction
endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// settle_timer: loadable down-counter that flags when a vector has been held SETTLE cycles
module settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);
  localparam int W = $clog2(SETTLE + 1);
  logic [W-1:0] cnt;
  assign expired = cnt == '0;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? W'(SETTLE - 1) : (expired ? cnt : cnt - 1'b1);
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: clocked exhaustive sweep of an N_IN-input function, capturing and checking its truth table
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int SETTLE = 1,
  localparam int N_VEC = n_vec(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_VEC-1:0] expected,
  output logic [N_IN-1:0]  x,
  input  logic             f,
  output logic             busy,
  output logic             done,
  output logic [N_VEC-1:0] table_q,
  output logic [N_VEC-1:0] mismatch,
  output logic             pass
);
  localparam logic [N_IN:0] last_idx = (N_IN + 1)'(N_VEC - 1);
  sweep_state_t state;
  logic [N_IN:0] idx;
  logic [N_VEC-1:0] exp_q, tbl_next;
  logic expired, last, load;
  assign last = idx == last_idx;
  assign load = (state == IDLE && start) || (state == SAMPLE && !last);
  assign busy = state != IDLE;
  assign done = state == FINISH;
  // final table including the bit sampled this cycle, so the verdict lands on the same edge
  always_comb begin
    tbl_next = table_q;
    tbl_next[idx[N_IN-1:0]] = f;
  end
  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .expired (expired)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state    <= IDLE;
      x        <= '0;
      idx      <= '0;
      exp_q    <= '0;
      table_q  <= '0;
      mismatch <= '0;
      pass     <= 1'b0;
    end else
      case (state)
        IDLE:
          if (start) begin
            exp_q    <= expected;
            table_q  <= '0;
            mismatch <= '0;
            pass     <= 1'b0;
            idx      <= '0;
            x        <= '0;
            state    <= sweeper_pkg::SETTLE;
          end
        sweeper_pkg::SETTLE: state <= expired ? SAMPLE : sweeper_pkg::SETTLE;
        SAMPLE: begin
          table_q <= tbl_next;
          if (last) begin
            mismatch <= tbl_next ^ exp_q;
            pass     <= tbl_next == exp_q;
            state    <= FINISH;
          end else begin
            idx   <= idx + 1'b1;
            x     <= x + 1'b1;
            state <= sweeper_pkg::SETTLE;
          end
        end
        FINISH: begin
          x     <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: randomized and directed sweeps of two sweeper instances (SETTLE=1 and SETTLE=3)
module tb_truth_table_sweeper;
  logic clk = 0, rst_n = 0, start = 0, sel3 = 0;
  logic [7:0] expected = '0, rt = '0;
  int mode = 0;
  int passed = 0, total = 0;
  logic [2:0] x1, x3, ox;
  logic f1, f3, busy1, busy3, done1, done3, pass1, pass3, obusy, odone, opass;
  logic [7:0] tq1, tq3, mm1, mm3, otq, omm;

  always #5 clk = ~clk;

  function automatic logic fval(input int m, input logic [2:0] v, input logic [7:0] tbl);
    return m == 0 ? v[0] : m == 1 ? ($countones(v) >= 2) : m == 2 ? 1'b0 : m == 3 ? v[2] : tbl[v];
  endfunction

  always_comb f1 = fval(mode, x1, rt);
  always_comb f3 = fval(mode, x3, rt);

  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start && !sel3), .expected(expected), .x(x1), .f(f1),
    .busy(busy1), .done(done1), .table_q(tq1), .mismatch(mm1), .pass(pass1)
  );
  truth_table_sweeper #(.N_IN(3), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start && sel3), .expected(expected), .x(x3), .f(f3),
    .busy(busy3), .done(done3), .table_q(tq3), .mismatch(mm3), .pass(pass3)
  );

  assign ox    = sel3 ? x3 : x1;
  assign obusy = sel3 ? busy3 : busy1;
  assign odone = sel3 ? done3 : done1;
  assign otq   = sel3 ? tq3 : tq1;
  assign omm   = sel3 ? mm3 : mm1;
  assign opass = sel3 ? pass3 : pass1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one sweep; each vector i must be visible for exactly s+1 cycles starting one cycle after the accepting edge.
  task automatic run_sweep(input int s, input int pulse_at, output int lat, output int dones,
                           output bit xbad, output bit bbad);
    int tot, ex;
    tot = 8 * (s + 1) + 1;
    lat = -1; dones = 0; xbad = 0; bbad = 0;
    start = 1;
    tick;
    start = 0;
    for (int k = 1; k <= tot + 2; k++) begin
      ex = k <= tot ? ((k - 1) / (s + 1) > 7 ? 7 : (k - 1) / (s + 1)) : 0;
      if (ox !== 3'(ex)) xbad = 1;
      if (obusy !== (k <= tot)) bbad = 1;
      if (odone === 1'b1) begin
        dones++;
        if (lat < 0) lat = k;
      end
      start = (k == pulse_at);
      tick;
    end
    start = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    tick;
    tick;
    total++;
    if ({x1, busy1, done1, tq1, mm1, pass1} !== 22'd0) $display("FAIL reset_s1: got %h want 0", {x1, busy1, done1, tq1, mm1, pass1});
    else passed++;
    total++;
    if ({x3, busy3, done3, tq3, mm3, pass3} !== 22'd0) $display("FAIL reset_s3: got %h want 0", {x3, busy3, done3, tq3, mm3, pass3});
    else passed++;
    rst_n = 1;
    tick;
  endtask

  task automatic test_sweep(input string name, input int m, input int s, input logic [7:0] e, input int pulse_at);
    int lat, dones;
    bit xbad, bbad;
    logic [7:0] ref_tbl;
    mode = m; sel3 = (s == 3); expected = e;
    for (int i = 0; i < 8; i++) ref_tbl[i] = fval(m, 3'(i), rt);
    run_sweep(s, pulse_at, lat, dones, xbad, bbad);
    total++;
    if (lat !== 8 * (s + 1) + 1) $display("FAIL %s latency: got %0d want %0d", name, lat, 8 * (s + 1) + 1);
    else passed++;
    total++;
    if (dones !== 1) $display("FAIL %s done_count: got %0d want 1", name, dones);
    else passed++;
    total++;
    if (xbad || bbad) $display("FAIL %s x/busy timeline: x_bad=%0d busy_bad=%0d want 0", name, xbad, bbad);
    else passed++;
    total++;
    if (otq !== ref_tbl) $display("FAIL %s table_q: got %h want %h", name, otq, ref_tbl);
    else passed++;
    total++;
    if (omm !== (ref_tbl ^ e)) $display("FAIL %s mismatch: got %h want %h", name, omm, ref_tbl ^ e);
    else passed++;
    total++;
    if (opass !== (ref_tbl == e)) $display("FAIL %s pass: got %b want %b", name, opass, ref_tbl == e);
    else passed++;
    sel3 = 0;
  endtask

  task automatic test_back_to_back;
    int d1 = -1, d2 = -1, nd = 0;
    logic b18 = 1'bx, b19 = 1'bx;
    mode = 1; sel3 = 0; expected = 8'hE8;
    start = 1;
    tick;
    for (int k = 1; k <= 40; k++) begin
      if (done1 === 1'b1) begin
        nd++;
        if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
      end
      if (k == 18) b18 = busy1;
      if (k == 19) b19 = busy1;
      if (k == 20) start = 0;
      tick;
    end
    total++;
    if (d1 !== 17 || d2 !== 35) $display("FAIL b2b done_times: got %0d,%0d want 17,35", d1, d2);
    else passed++;
    total++;
    if ({b18, b19} !== 2'b01) $display("FAIL b2b idle_gap busy: got %b want 01", {b18, b19});
    else passed++;
    total++;
    if (nd !== 2) $display("FAIL b2b done_count: got %0d want 2", nd);
    else passed++;
    total++;
    if ({tq1, pass1} !== {8'hE8, 1'b1}) $display("FAIL b2b result: got %h/%b want e8/1", tq1, pass1);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int nd = 0;
    bit bsy = 0;
    mode = 0; sel3 = 0; expected = 8'hAA;
    start = 1;
    tick;
    start = 0;
    for (int k = 1; k < 9; k++) tick;
    rst_n = 0;
    tick;
    total++;
    if ({x1, busy1, done1, tq1, mm1, pass1} !== 22'd0) $display("FAIL reset_mid outputs: got %h want 0", {x1, busy1, done1, tq1, mm1, pass1});
    else passed++;
    rst_n = 1;
    for (int k = 0; k < 20; k++) begin
      if (done1 === 1'b1) nd++;
      if (busy1 !== 1'b0) bsy = 1;
      tick;
    end
    total++;
    if (nd !== 0 || bsy) $display("FAIL reset_mid quiet: done_count=%0d busy_seen=%0d want 0,0", nd, bsy);
    else passed++;
    test_sweep("after_reset", 0, 1, 8'hAA, 0);
  endtask

  task automatic test_random;
    logic [7:0] e;
    for (int n = 0; n < 4; n++) begin
      rt = 8'($urandom);
      e = $urandom_range(0, 1) ? rt : rt ^ 8'($urandom);
      test_sweep("random", 4, ($urandom_range(0, 1) != 0) ? 3 : 1, e, 0);
    end
  endtask

  initial begin
    test_reset;
    test_sweep("f_x0", 0, 1, 8'hAA, 0);
    test_sweep("majority", 1, 1, 8'hE8, 0);
    test_sweep("f_zero", 2, 1, 8'hAA, 0);
    test_sweep("settle3", 3, 3, 8'hF0, 0);
    test_sweep("start_ignored", 0, 1, 8'hAA, 5);
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
